// File: rtl/spi_flash_arbiter_pkg.sv
// spi_flash_arbiter_pkg: shared state encoding, W25Q32 opcodes and timing constants
package spi_flash_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE,
    OWN0,
    OWN1,
    GAP,
    POLL_CMD,
    POLL_RD,
    POLL_CHK
  } state_e;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] WIP_MASK = 8'h01;
  localparam logic [2:0] GAP_LEN = 3'd4;
  localparam int unsigned POLL_MAX = 65535;
endpackage

// File: rtl/spi_status_poller.sv
// spi_status_poller: RDSR command shifter, status capture and WIP timeout tracking
// Ports: MCLK/nRESET clock and async active-low reset; clr restarts the poll count;
// run/rd/chk flag the command+read, read and check phases; miso status input;
// sclk/mosi flash pins while running; cmd_done/rd_done end of each byte;
// wip latest WIP bit; timeout WIP still set on the final allowed poll.
module spi_status_poller
  import spi_flash_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = POLL_MAX
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic clr,
  input  logic run,
  input  logic rd,
  input  logic chk,
  input  logic miso,
  output logic sclk,
  output logic mosi,
  output logic cmd_done,
  output logic rd_done,
  output logic wip,
  output logic timeout
);
  logic phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic [15:0] iter_q, iter_d;
  always_comb begin
    phase_d = run && !phase_q;
    bit_d = run ? bit_q + {2'b00, phase_q} : 3'd0;
    sr_d = rd && phase_q ? {sr_q[6:0], miso} : sr_q;
    iter_d = clr ? 16'd0 : chk && wip && iter_q != 16'hFFFF ? iter_q + 16'd1 : iter_q;
  end
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      phase_q <= 1'b0;
      bit_q <= 3'd0;
      sr_q <= 8'd0;
      iter_q <= 16'd0;
    end else begin
      phase_q <= phase_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      iter_q <= iter_d;
    end
  end
  // phase 0 is the CLK-low half of a bit, phase 1 the CLK-high half where MISO is sampled
  assign sclk = !run || phase_q;
  assign mosi = run && !rd && OP_RDSR[3'd7 - bit_q];
  assign cmd_done = run && !rd && phase_q && &bit_q;
  assign rd_done = rd && phase_q && &bit_q;
  assign wip = (sr_q & WIP_MASK) != 8'd0;
  assign timeout = chk && wip && {16'd0, iter_q} >= LIMIT - 32'd1;
endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: two-requester W25Q32 SPI bus arbiter with optional WIP polling
// Build option: define SPIARB_WIP_POLL_EN to poll RDSR after every requester-1 tenure.
// Ports: MCLK/nRESET clock and async active-low reset; nREQx/nGNTx active-low
// request/grant (0 = read loader, 1 = write-back, 0 has priority); Rx_nCS/Rx_CLK/
// Rx_MOSI requester pins; nCS/CLK/MOSI/MISO flash pins; BUSY bus not idle;
// POLLERR sticky poll timeout.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = POLL_MAX
) (
  input  logic MCLK,
  input  logic nRESET,
  input  logic nREQ0,
  input  logic nREQ1,
  output logic nGNT0,
  output logic nGNT1,
  input  logic R0_nCS,
  input  logic R0_CLK,
  input  logic R0_MOSI,
  input  logic R1_nCS,
  input  logic R1_CLK,
  input  logic R1_MOSI,
  output logic nCS,
  output logic CLK,
  output logic MOSI,
  input  logic MISO,
  output logic BUSY,
  output logic POLLERR
);
  state_e state_q, state_d, gap_next;
  logic [2:0] cnt_q, cnt_d;
  logic own0, own1, poll_bus, p_sclk, p_mosi;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign poll_bus = state_q == POLL_CMD || state_q == POLL_RD;
`ifdef SPIARB_WIP_POLL_EN
  logic poll_q, poll_d, err_q, err_d, cmd_done, rd_done, wip, timeout;
  spi_status_poller #(.LIMIT(POLL_LIMIT)) u_poller (
    .MCLK(MCLK),
    .nRESET(nRESET),
    .clr(own1 && nREQ1),
    .run(poll_bus),
    .rd(state_q == POLL_RD),
    .chk(state_q == POLL_CHK),
    .miso(MISO),
    .sclk(p_sclk),
    .mosi(p_mosi),
    .cmd_done(cmd_done),
    .rd_done(rd_done),
    .wip(wip),
    .timeout(timeout)
  );
  // poll_q marks a write-back that still needs its WIP status confirmed
  assign gap_next = poll_q ? POLL_CMD : IDLE;
  assign POLLERR = err_q;
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      poll_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      poll_q <= poll_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_poll;
  assign unused_poll = MISO ^ POLL_LIMIT[0];
  assign gap_next = IDLE;
  assign p_sclk = 1'b1;
  assign p_mosi = 1'b0;
  assign POLLERR = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = 3'd0;
`ifdef SPIARB_WIP_POLL_EN
    poll_d = poll_q || (own1 && nREQ1);
    err_d = err_q;
`endif
    case (state_q)
      IDLE: state_d = !nREQ0 ? OWN0 : !nREQ1 ? OWN1 : IDLE;
      OWN0: state_d = nREQ0 ? GAP : OWN0;
      OWN1: state_d = nREQ1 ? GAP : OWN1;
      GAP: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == GAP_LEN - 3'd1) begin
          cnt_d = 3'd0;
          state_d = gap_next;
        end
      end
`ifdef SPIARB_WIP_POLL_EN
      POLL_CMD: state_d = cmd_done ? POLL_RD : POLL_CMD;
      POLL_RD: state_d = rd_done ? POLL_CHK : POLL_RD;
      POLL_CHK: begin
        // every frame is followed by a tSHSL gap, even the timeout exit
        state_d = GAP;
        poll_d = wip && !timeout;
        err_d = err_q || timeout;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign nGNT0 = !own0;
  assign nGNT1 = !own1;
  assign BUSY = state_q != IDLE;
  assign nCS = own0 ? R0_nCS : own1 ? R1_nCS : !poll_bus;
  assign CLK = own0 ? R0_CLK : own1 ? R1_CLK : !poll_bus || p_sclk;
  assign MOSI = own0 ? R0_MOSI : own1 ? R1_MOSI : poll_bus && p_mosi;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: table-driven arbitration vectors plus flash-model corner sequences
module tb_spi_flash_arbiter;
  localparam int LIM = 8;
  logic MCLK = 1'b0, nRESET = 1'b0, nREQ0 = 1'b0, nREQ1 = 1'b0;
  logic R0_nCS = 1'b1, R0_CLK = 1'b1, R0_MOSI = 1'b0;
  logic R1_nCS = 1'b1, R1_CLK = 1'b1, R1_MOSI = 1'b0, MISO = 1'b0;
  logic nGNT0, nGNT1, nCS, CLK, MOSI, BUSY, POLLERR;
  int total = 0, bad = 0;

  spi_flash_arbiter #(.POLL_LIMIT(LIM)) dut (
    .MCLK(MCLK), .nRESET(nRESET), .nREQ0(nREQ0), .nREQ1(nREQ1),
    .nGNT0(nGNT0), .nGNT1(nGNT1),
    .R0_nCS(R0_nCS), .R0_CLK(R0_CLK), .R0_MOSI(R0_MOSI),
    .R1_nCS(R1_nCS), .R1_CLK(R1_CLK), .R1_MOSI(R1_MOSI),
    .nCS(nCS), .CLK(CLK), .MOSI(MOSI), .MISO(MISO),
    .BUSY(BUSY), .POLLERR(POLLERR)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic nreq0;
    logic nreq1;
    logic [2:0] r0;
    logic [2:0] r1;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];
  logic [5:0] sb_q[$];

  // flash model: mode-3 slave that answers RDSR with queued status bytes
  logic pcs = 1'b1, pclk = 1'b1;
  int bitn = 0, rdsr_n = 0;
  logic [7:0] cmd = 8'd0, stat_out = 8'd0, stuck = 8'd0;
  logic [7:0] stat_q[$];
  always @(nCS or CLK) begin
    if (nCS != pcs) begin
      if (!nCS) begin
        bitn = 0;
        cmd = 8'd0;
      end else if (cmd == 8'h05 && bitn == 16) rdsr_n++;
    end else if (!nCS && CLK && !pclk) begin
      if (bitn < 8) cmd = {cmd[6:0], MOSI};
      bitn++;
      if (bitn == 8 && cmd == 8'h05) begin
        if (stat_q.size() > 0) stat_out = stat_q.pop_front();
        else stat_out = stuck;
      end
    end else if (!nCS && !CLK && pclk && bitn >= 8 && bitn < 16) MISO = stat_out[15-bitn];
    pcs = nCS;
    pclk = CLK;
  end

  int hi = 0, min_hi = 1000;
  logic mon_en = 1'b0;
  always @(posedge MCLK) begin
    hi <= nCS ? hi + 1 : 0;
    if (!nCS && mon_en && hi > 0 && hi < min_hi) min_hi <= hi;
  end

  function automatic vec_t mk(logic a, logic b, logic [2:0] r0, logic [2:0] r1, logic [5:0] e);
    vec_t v;
    v.nreq0 = a;
    v.nreq1 = b;
    v.r0 = r0;
    v.r1 = r1;
    v.exp = e;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {nGNT0, nGNT1, nCS, CLK, MOSI, BUSY};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(logic a, logic b);
    @(negedge MCLK);
    nREQ0 = a;
    nREQ1 = b;
    @(posedge MCLK);
    #1;
  endtask

  task automatic wait_idle(int max, string name);
    int n = 0;
    while (BUSY && n < max) begin
      @(posedge MCLK);
      #1;
      n++;
    end
    chk(name, BUSY, 0);
  endtask

  task automatic mid_reset(string tag);
    #2 nRESET = 1'b0;
    nREQ0 = 1'b0;
    #1;
    chk({tag, "_ncs"}, nCS, 1);
    chk({tag, "_clk"}, CLK, 1);
    chk({tag, "_gnt"}, {nGNT0, nGNT1}, 2'b11);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_err"}, POLLERR, 0);
    repeat (2) @(posedge MCLK);
    #1;
    chk({tag, "_held"}, nGNT0, 1);
    @(negedge MCLK);
    nREQ0 = 1'b1;
    #2 nRESET = 1'b1;
    @(posedge MCLK);
    #1;
    chk({tag, "_norel"}, {nGNT0, BUSY}, 2'b10);
    cyc(1'b0, 1'b1);
    chk({tag, "_regrant"}, nGNT0, 0);
    cyc(1'b1, 1'b1);
    wait_idle(10, {tag, "_idle"});
  endtask

  initial begin
    logic [7:0] pat;
    logic [5:0] e;
    int n, base, lows;
    pat = 8'h03;
    tbl.push_back(mk(1, 1, 3'b110, 3'b001, 6'b111100));
    tbl.push_back(mk(0, 0, 3'b110, 3'b001, 6'b011101));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(0, 0, {2'b00, pat[7-i]}, {2'b11, ~pat[7-i]}, {4'b0100, pat[7-i], 1'b1}));
      tbl.push_back(mk(0, 0, {2'b01, pat[7-i]}, {2'b10, ~pat[7-i]}, {4'b0101, pat[7-i], 1'b1}));
    end
    repeat (4) tbl.push_back(mk(1, 0, 3'b001, 3'b001, 6'b111101));
    tbl.push_back(mk(1, 0, 3'b000, 3'b001, 6'b111100));
    tbl.push_back(mk(1, 0, 3'b000, 3'b011, 6'b100111));
    tbl.push_back(mk(0, 0, 3'b111, 3'b000, 6'b100001));
    tbl.push_back(mk(1, 0, 3'b000, 3'b010, 6'b100101));
    repeat (4) tbl.push_back(mk(1, 1, 3'b000, 3'b001, 6'b111101));
    stat_q.push_back(8'h01);
    stat_q.push_back(8'h01);
    stat_q.push_back(8'h00);

    repeat (3) @(posedge MCLK);
    #1;
    chk("rst_outs", outs(), 6'b111100);
    chk("rst_err", POLLERR, 0);
    @(negedge MCLK);
    nREQ0 = 1'b1;
    nREQ1 = 1'b1;
    #2 nRESET = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge MCLK);
      nREQ0 = tbl[i].nreq0;
      nREQ1 = tbl[i].nreq1;
      {R0_nCS, R0_CLK, R0_MOSI} = tbl[i].r0;
      {R1_nCS, R1_CLK, R1_MOSI} = tbl[i].r1;
      sb_q.push_back(tbl[i].exp);
      @(posedge MCLK);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("vec%0d", i), outs(), e);
    end

`ifdef SPIARB_WIP_POLL_EN
    mon_en = 1'b1;
    base = rdsr_n;
    wait_idle(400, "poll3_idle");
    chk("poll3_frames", rdsr_n - base, 3);
    chk("poll3_gap", min_hi >= 4, 1);
    chk("poll3_status_used", stat_q.size(), 0);
    chk("poll3_err", POLLERR, 0);

    stuck = 8'h01;
    base = rdsr_n;
    cyc(1'b1, 1'b0);
    chk("stuck_gnt1", nGNT1, 0);
    cyc(1'b1, 1'b1);
    wait_idle(LIM * 40 + 50, "stuck_idle");
    chk("stuck_err", POLLERR, 1);
    chk("stuck_frames", rdsr_n - base, LIM);
    cyc(1'b0, 1'b1);
    chk("stuck_gnt0", nGNT0, 0);
    cyc(1'b1, 1'b1);
    wait_idle(10, "stuck_rel");

    cyc(1'b1, 1'b0);
    chk("rd3_gnt1", nGNT1, 0);
    cyc(1'b1, 1'b1);
    n = 0;
    while (nCS && n < 20) begin
      @(posedge MCLK);
      #1;
      n++;
    end
    chk("rd3_gap", n, 4);
    repeat (22) @(posedge MCLK);
    #1;
    chk("rd3_clk_low", {nCS, CLK}, 2'b00);
    mid_reset("rst_poll");
`else
    @(posedge MCLK);
    #1;
    chk("gap_to_idle", outs(), 6'b111100);
    lows = 0;
    repeat (40) begin
      @(posedge MCLK);
      #1;
      if (!nCS) lows++;
    end
    chk("no_rdsr", lows, 0);
    chk("err_tied", POLLERR, 0);
    @(negedge MCLK);
    {R0_nCS, R0_CLK} = 2'b00;
    nREQ0 = 1'b0;
    @(posedge MCLK);
    #1;
    chk("own0_cs", {nGNT0, nCS}, 2'b00);
    mid_reset("rst_own0");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
